if_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the 5-stage pipeline; sits directly upstream of the instruction-field decoder.
- Holds the word-addressed PC and drives the instruction-memory address.
- Latches the returned 32-bit instruction word plus PC+1 into the IF/ID register.
- Honours hazard-unit stalls and branch/jump redirects from later stages; the decoder consumes ifid_instr unchanged.

---
 rtl/if_stage.sv | 59 +++++
 tb/tb_if_stage.sv | 115 +++++++++++
 2 files changed

// File: rtl/if_stage.sv
// if_stage: fetch PC register and IF/ID pipeline latch with stall, redirect and fetch/squash counters.
module if_stage #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           pc,
  output logic [31:0]           ifid_instr,
  output logic [31:0]           ifid_pc_plus1,
  output logic                  ifid_valid,
  output logic [31:0]           fetch_count,
  output logic [15:0]           squash_count
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pp1_q, pp1_d, fcnt_q, fcnt_d;
  logic [15:0] scnt_q, scnt_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_inc;
  assign pc_inc = pc_q + 32'd1;
  // Redirect outranks stall; imem_rdata is only selected on a normal edge so X cannot leak in.
  always_comb begin
    pc_d    = redirect_valid ? redirect_pc : stall ? pc_q    : pc_inc;
    instr_d = redirect_valid ? NOP_WORD    : stall ? instr_q : imem_rdata;
    pp1_d   = redirect_valid ? 32'd0       : stall ? pp1_q   : pc_inc;
    valid_d = redirect_valid ? 1'b0        : stall ? valid_q : 1'b1;
    fcnt_d  = (redirect_valid || stall) ? fcnt_q : fcnt_q + 32'd1;
    scnt_d  = (redirect_valid && scnt_q != 16'hFFFF) ? scnt_q + 16'd1 : scnt_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pp1_q   <= 32'd0;
      valid_q <= 1'b0;
      fcnt_q  <= 32'd0;
      scnt_q  <= 16'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp1_q   <= pp1_d;
      valid_q <= valid_d;
      fcnt_q  <= fcnt_d;
      scnt_q  <= scnt_d;
    end
  end
  assign imem_addr     = pc_q[ADDR_WIDTH-1:0];
  assign pc            = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus1 = pp1_q;
  assign ifid_valid    = valid_q;
  assign fetch_count   = fcnt_q;
  assign squash_count  = scnt_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed test-plan sequences plus random stall/redirect traffic against a behavioural fetch model.
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] NOP    = 32'h0;
  logic        clock = 1'b0;
  logic        reset_n, stall, redirect_valid, x_mode;
  logic [31:0] redirect_pc, imem_rdata, pc, ifid_instr, ifid_pc_plus1, fetch_count;
  logic [11:0] imem_addr;
  logic        ifid_valid;
  logic [15:0] squash_count;
  int          compared = 0, mismatched = 0;
  logic [31:0] m_pc, m_instr, m_pp1, m_fcnt;
  logic [15:0] m_scnt;
  logic        m_valid;

  if_stage #(.ADDR_WIDTH(12), .RESET_PC(RST_PC), .NOP_WORD(NOP)) dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .ifid_instr(ifid_instr), .ifid_pc_plus1(ifid_pc_plus1), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count), .squash_count(squash_count)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 | (a & 32'h0000_0FFF);
  endfunction

  assign imem_rdata = (x_mode && (stall || redirect_valid)) ? 32'hxxxx_xxxx : word({20'd0, imem_addr});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".pc"}, pc, m_pc);
    chk({ctx, ".imem_addr"}, {20'd0, imem_addr}, m_pc & 32'hFFF);
    chk({ctx, ".instr"}, ifid_instr, m_instr);
    chk({ctx, ".pc_plus1"}, ifid_pc_plus1, m_pp1);
    chk({ctx, ".valid"}, {31'd0, ifid_valid}, {31'd0, m_valid});
    chk({ctx, ".fetch_count"}, fetch_count, m_fcnt);
    chk({ctx, ".squash_count"}, {16'd0, squash_count}, {16'd0, m_scnt});
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_instr = NOP; m_pp1 = 0; m_valid = 0; m_fcnt = 0; m_scnt = 0;
  endtask

  task automatic step(input string ctx, input logic s, input logic r, input logic [31:0] rp);
    stall = s; redirect_valid = r; redirect_pc = rp;
    @(posedge clock);
    if (r) begin
      m_pc = rp; m_instr = NOP; m_pp1 = 0; m_valid = 0;
      if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 1;
    end else if (!s) begin
      m_instr = word(m_pc); m_pp1 = m_pc + 1; m_valid = 1; m_pc = m_pc + 1; m_fcnt = m_fcnt + 1;
    end
    @(negedge clock);
    check_all(ctx);
  endtask

  initial begin
    reset_n = 0; stall = 0; redirect_valid = 0; redirect_pc = 0; x_mode = 0;
    model_reset();
    #1 check_all("reset");
    @(negedge clock) reset_n = 1;
    for (int i = 0; i < 4; i++) step("run", 0, 0, 0);
    chk("run4.instr", ifid_instr, 32'h1000_0003);
    chk("run4.fcnt", fetch_count, 32'd4);
    step("to5", 0, 0, 0);
    for (int i = 0; i < 3; i++) step("stall", 1, 0, 0);
    chk("stall.pc", pc, 32'd5);
    chk("stall.instr", ifid_instr, 32'h1000_0004);
    step("release", 0, 0, 0);
    chk("release.instr", ifid_instr, 32'h1000_0005);
    for (int i = 0; i < 3; i++) step("to9", 0, 0, 0);
    chk("pre_redir.pc", pc, 32'd9);
    step("redir", 0, 1, 32'h40);
    chk("redir.scnt", {16'd0, squash_count}, 32'd1);
    step("target", 0, 0, 0);
    chk("target.instr", ifid_instr, 32'h1000_0040);
    chk("target.pp1", ifid_pc_plus1, 32'h41);
    step("stall_redir", 1, 1, 32'h20);
    chk("stall_redir.pc", pc, 32'h20);
    step("wrap_redir", 0, 1, 32'hFFFF_FFFF);
    chk("wrap.addr0", {20'd0, imem_addr}, 32'hFFF);
    step("wrap1", 0, 0, 0);
    chk("wrap1.pp1", ifid_pc_plus1, 32'd0);
    chk("wrap1.addr", {20'd0, imem_addr}, 32'h000);
    step("wrap2", 0, 0, 0);
    chk("wrap2.pc", pc, 32'd1);
    step("to33", 0, 1, 32'h33);
    step("pre_rst_stall", 1, 0, 0);
    #1 reset_n = 0;
    #1 model_reset(); check_all("async_rst");
    #1 reset_n = 1;
    step("restart", 0, 0, 0);
    chk("restart.instr", ifid_instr, 32'h1000_0000);
    x_mode = 1;
    for (int i = 0; i < 400; i++) begin
      logic s, r;
      logic [31:0] rp;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + {31'd0, 1'($urandom_range(0, 1))} : $urandom;
      step("rand", s, r, rp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
